// File: rtl/pad_reader_pkg.sv
// Shared types and helpers for the serial game-pad reader.
package pad_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SAMPLE,
    CLK_LO,
    CLK_HI,
    DONE
  } pad_state_t;

  // Cycles from entering LATCH to leaving DONE.
  function automatic int unsigned frame_cycles(input int unsigned pulse, input int unsigned bits);
    return pulse + bits + 2 * pulse * (bits - 1) + 1;
  endfunction

endpackage

// File: rtl/serial_pad_reader_if.sv
// Controller pins plus decoded button state of the serial pad reader.
interface serial_pad_reader_if #(
  parameter int unsigned NUM_PADS = 2,
  parameter int unsigned BITS     = 8
);
  logic                     enable;
  logic [NUM_PADS-1:0]      pad_data;
  logic                     pad_latch;
  logic                     pad_clk;
  logic [NUM_PADS*BITS-1:0] buttons;
  logic [NUM_PADS*BITS-1:0] pressed;
  logic [NUM_PADS*BITS-1:0] released;
  logic                     frame_ok;
  logic                     busy;

  modport master (
    input  enable, pad_data,
    output pad_latch, pad_clk, buttons, pressed, released, frame_ok, busy
  );

  modport slave (
    output enable, pad_data,
    input  pad_latch, pad_clk, buttons, pressed, released, frame_ok, busy
  );
endinterface

// File: rtl/pad_poll_tick.sv
// Single-cycle frame-start strobe, high whenever the free-running counter is 0.
module pad_poll_tick #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned POLL_HZ = 750
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int unsigned DIV = CLK_HZ / POLL_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (count == CW'(DIV - 1))
      count <= '0;
    else
      count <= count + CW'(1);
  end

  assign tick = (count == '0);
endmodule

// File: rtl/serial_pad_reader.sv
// Polls NUM_PADS serial controllers over a shared latch/clock and publishes
// held, pressed and released masks once per frame.
module serial_pad_reader
  import pad_reader_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned POLL_HZ      = 750,
  parameter int unsigned PULSE_CYCLES = 300,
  parameter int unsigned NUM_PADS     = 2,
  parameter int unsigned BITS         = 8
) (
  input logic                 clock,
  input logic                 reset,
  serial_pad_reader_if.master bus
);
  localparam int unsigned PW = $clog2(PULSE_CYCLES);
  localparam int unsigned IW = $clog2(BITS);
  localparam int unsigned W  = NUM_PADS * BITS;

  if (PULSE_CYCLES < 4) begin : g_chk_pulse
    $error("PULSE_CYCLES must be at least 4");
  end
  if (NUM_PADS < 1 || BITS < 2 || BITS > 32) begin : g_chk_shape
    $error("NUM_PADS must be >=1 and BITS within 2..32");
  end
  if (frame_cycles(PULSE_CYCLES, BITS) >= CLK_HZ / POLL_HZ) begin : g_chk_frame
    $error("frame does not fit between poll ticks");
  end

  logic                     tick;
  pad_state_t               state, state_nxt;
  logic [PW-1:0]            phase;
  logic [IW-1:0]            bit_idx;
  logic                     phase_end, last_bit;
  logic [NUM_PADS-1:0]      sync_a, sync_q;
  logic [BITS-1:0][NUM_PADS-1:0] shift_q;
  logic [W-1:0]             frame_bits;
  logic                     latch_q, clk_q, busy_q, frame_ok_q;
  logic [W-1:0]             buttons_q, pressed_q, released_q;

  pad_poll_tick #(.CLK_HZ(CLK_HZ), .POLL_HZ(POLL_HZ)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= '1;
      sync_q <= '1;
    end else begin
      sync_a <= bus.pad_data;
      sync_q <= sync_a;
    end
  end

  assign phase_end = (phase == PW'(PULSE_CYCLES - 1));
  assign last_bit  = (bit_idx == IW'(BITS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (tick && bus.enable) state_nxt = LATCH;
      LATCH:   if (phase_end) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_bit ? DONE : CLK_LO;
      CLK_LO:  if (phase_end) state_nxt = CLK_HI;
      CLK_HI:  if (phase_end) state_nxt = SAMPLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register is stored bit-major so a sample writes all pads at once;
  // this transpose restores the pad-major output layout.
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    for (genvar i = 0; i < BITS; i++) begin : g_bit
      assign frame_bits[p*BITS + i] = shift_q[i][p];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase      <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      latch_q    <= 1'b0;
      clk_q      <= 1'b1;
      busy_q     <= 1'b0;
      frame_ok_q <= 1'b0;
      buttons_q  <= '0;
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      phase      <= (state_nxt != state) ? '0 : phase + PW'(1);
      latch_q    <= (state_nxt == LATCH);
      clk_q      <= (state_nxt != CLK_LO);
      busy_q     <= (state_nxt != IDLE);
      frame_ok_q <= (state == DONE);
      pressed_q  <= '0;
      released_q <= '0;
      if (state == SAMPLE) begin
        shift_q[bit_idx] <= ~sync_q;
        if (!last_bit) bit_idx <= bit_idx + IW'(1);
      end
      if (state == DONE) begin
        buttons_q  <= frame_bits;
        pressed_q  <= frame_bits & ~buttons_q;
        released_q <= ~frame_bits & buttons_q;
        bit_idx    <= '0;
      end
    end
  end

  assign bus.pad_latch = latch_q;
  assign bus.pad_clk   = clk_q;
  assign bus.busy      = busy_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.buttons   = buttons_q;
  assign bus.pressed   = pressed_q;
  assign bus.released  = released_q;
endmodule
